// File: rtl/demux4_stream_if.sv
// Stream demux bundle: one producer-side input, four consumer-side outputs.
// The slave modport is the demux; the master modport drives it.
interface demux4_stream_if #(
    parameter int DataWidth = 32
);
    logic [1:0]           sel_i;
    logic [DataWidth-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [DataWidth-1:0] out0_data_o;
    logic [DataWidth-1:0] out1_data_o;
    logic [DataWidth-1:0] out2_data_o;
    logic [DataWidth-1:0] out3_data_o;
    logic [3:0]           valid_o;
    logic [3:0]           ready_i;

    modport slave (
        input  sel_i,
        input  data_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output out0_data_o,
        output out1_data_o,
        output out2_data_o,
        output out3_data_o,
        output valid_o
    );

    modport master (
        output sel_i,
        output data_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  out0_data_o,
        input  out1_data_o,
        input  out2_data_o,
        input  out3_data_o,
        input  valid_o
    );
endinterface

// File: rtl/demux4_stream.sv
// Buffered 1-to-4 stream demultiplexer.
// Each output channel owns a 2-entry FIFO so one stalled consumer blocks only itself.
module demux4_stream #(
    parameter int DataWidth = 32
) (
    input logic            clk_i,
    input logic            rst_ni,
    demux4_stream_if.slave bus
);
    logic [DataWidth-1:0] mem [4][2];
    logic [3:0]           rptr;
    logic [3:0]           wptr;
    logic [1:0]           occ [4];
    logic                 ready;
    logic [3:0]           psh;
    logic [3:0]           pop;
    logic [3:0]           vld;

    // Depends only on sel and stored occupancy, never on consumer ready.
    assign ready = (occ[bus.sel_i] != 2'd2);
    assign bus.ready_o = ready;
    assign bus.valid_o = vld;

    always_comb begin
        psh = '0;
        pop = '0;
        vld = '0;
        for (int k = 0; k < 4; k++) begin
            vld[k] = (occ[k] != 2'd0);
            pop[k] = vld[k] && bus.ready_i[k];
            psh[k] = bus.valid_i && ready
                     && (bus.sel_i == 2'(k));
        end
    end

    assign bus.out0_data_o = mem[0][rptr[0]];
    assign bus.out1_data_o = mem[1][rptr[1]];
    assign bus.out2_data_o = mem[2][rptr[2]];
    assign bus.out3_data_o = mem[3][rptr[3]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr <= '0;
            wptr <= '0;
            for (int k = 0; k < 4; k++) begin
                occ[k]    <= 2'd0;
                mem[k][0] <= '0;
                mem[k][1] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (psh[k]) begin
                    mem[k][wptr[k]] <= bus.data_i;
                    wptr[k]         <= ~wptr[k];
                end
                if (pop[k]) begin
                    rptr[k] <= ~rptr[k];
                end
                if (psh[k] && !pop[k]) begin
                    occ[k] <= occ[k] + 2'd1;
                end else if (!psh[k] && pop[k]) begin
                    occ[k] <= occ[k] - 2'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_chk
        a_no_over : assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            occ[g] != 2'd3
        );
        a_full_push : assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            psh[g] |-> occ[g] != 2'd2
        );
        a_no_under : assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            pop[g] |-> occ[g] != 2'd0
        );
    end
endmodule

// File: tb/tb_demux4_stream.sv
// Directed bench for demux4_stream with a queue-based reference model.
// A negedge compare process checks every DUT output against the model.
module tb_demux4_stream;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   max_occ0 = 0;

    logic [31:0] q [4][$];

    demux4_stream_if #(.DataWidth(32)) bus ();

    demux4_stream #(.DataWidth(32)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_data(int k);
        case (k)
            0: return bus.out0_data_o;
            1: return bus.out1_data_o;
            2: return bus.out2_data_o;
            default: return bus.out3_data_o;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: per-channel queues of capacity two.
    always @(negedge rst_ni) begin
        for (int k = 0; k < 4; k++) q[k].delete();
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            bit [3:0] pp;
            bit       ps;
            int       s;
            s  = int'(bus.sel_i);
            ps = bus.valid_i && (q[s].size() != 2);
            for (int k = 0; k < 4; k++)
                pp[k] = (q[k].size() != 0) && bus.ready_i[k];
            for (int k = 0; k < 4; k++)
                if (pp[k]) void'(q[k].pop_front());
            if (ps) q[s].push_back(bus.data_i);
            if (q[0].size() > max_occ0) max_occ0 = q[0].size();
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            int s;
            s = int'(bus.sel_i);
            chk("ready_o", 32'(bus.ready_o), 32'(q[s].size() != 2));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("valid_o[%0d]", k), 32'(bus.valid_o[k]),
                    32'(q[k].size() != 0));
                if (q[k].size() != 0)
                    chk($sformatf("out%0d_data", k), out_data(k), q[k][0]);
            end
        end
    end

    task automatic push(logic [1:0] s, logic [31:0] d);
        bus.sel_i   = s;
        bus.data_i  = d;
        bus.valid_i = 1'b1;
        cyc();
        bus.valid_i = 1'b0;
    endtask

    initial begin
        bus.sel_i   = 2'd0;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.ready_i = 4'b0000;
        #2;
        chk("rst valid_o", 32'(bus.valid_o), 32'h0);
        for (int k = 0; k < 4; k++) begin
            bus.sel_i = 2'(k);
            #1;
            chk("rst ready_o", 32'(bus.ready_o), 32'h1);
            chk("rst data", out_data(k), 32'h0);
        end
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // single push and pop on channel 2
        push(2'd2, 32'hA5A5_0001);
        chk("single valid", 32'(bus.valid_o), 32'h4);
        chk("single data", bus.out2_data_o, 32'hA5A5_0001);
        bus.ready_i = 4'b0100;
        cyc();
        chk("single popped", 32'(bus.valid_o), 32'h0);
        bus.ready_i = 4'b0000;

        // backpressure on channel 1
        push(2'd1, 32'h11);
        push(2'd1, 32'h22);
        bus.sel_i   = 2'd1;
        bus.data_i  = 32'h33;
        bus.valid_i = 1'b1;
        #1 chk("bp full ready", 32'(bus.ready_o), 32'h0);
        bus.sel_i = 2'd3;
        #1 chk("bp other ready", 32'(bus.ready_o), 32'h1);
        bus.sel_i   = 2'd1;
        bus.ready_i = 4'b0010;
        #1 chk("bp head0", bus.out1_data_o, 32'h11);
        cyc();
        chk("bp head1", bus.out1_data_o, 32'h22);
        chk("bp retry ready", 32'(bus.ready_o), 32'h1);
        cyc();
        bus.valid_i = 1'b0;
        chk("bp head2", bus.out1_data_o, 32'h33);
        cyc();
        chk("bp drained", 32'(bus.valid_o), 32'h0);
        bus.ready_i = 4'b0000;

        // streaming to channel 0
        bus.ready_i = 4'b0001;
        max_occ0 = 0;
        for (int i = 0; i < 16; i++) begin
            bus.sel_i   = 2'd0;
            bus.data_i  = 32'h100 + 32'(i);
            bus.valid_i = 1'b1;
            #1 chk("stream ready", 32'(bus.ready_o), 32'h1);
            cyc();
            chk("stream valid", 32'(bus.valid_o), 32'h1);
            chk("stream data", bus.out0_data_o, 32'h100 + 32'(i));
        end
        bus.valid_i = 1'b0;
        cyc();
        chk("stream empty", 32'(bus.valid_o), 32'h0);
        chk("stream max occ", 32'(max_occ0), 32'h1);
        bus.ready_i = 4'b0000;

        // independence: channel 0 full and stalled
        push(2'd0, 32'hC0);
        push(2'd0, 32'hC1);
        bus.sel_i   = 2'd3;
        bus.data_i  = 32'hBEEF;
        bus.valid_i = 1'b1;
        #1 chk("ind ready", 32'(bus.ready_o), 32'h1);
        cyc();
        bus.valid_i = 1'b0;
        chk("ind valid", 32'(bus.valid_o), 32'h9);
        chk("ind data3", bus.out3_data_o, 32'hBEEF);
        bus.ready_i = 4'b1000;
        cyc();
        chk("ind popped", 32'(bus.valid_o), 32'h1);
        chk("ind head0", bus.out0_data_o, 32'hC0);
        bus.ready_i = 4'b0001;
        cyc();
        chk("ind next0", bus.out0_data_o, 32'hC1);
        cyc();
        bus.ready_i = 4'b0000;

        // push and pop together on channel 2
        push(2'd2, 32'h5);
        bus.ready_i = 4'b0100;
        push(2'd2, 32'h6);
        chk("pp valid", 32'(bus.valid_o), 32'h4);
        chk("pp head", bus.out2_data_o, 32'h6);
        cyc();
        chk("pp occ1", 32'(bus.valid_o), 32'h0);
        bus.ready_i = 4'b0000;

        // reset mid-stream with occupancies {2,1,0,2}
        push(2'd0, 32'hA0);
        push(2'd0, 32'hA1);
        push(2'd1, 32'hB0);
        push(2'd3, 32'hD0);
        push(2'd3, 32'hD1);
        chk("pre-rst valid", 32'(bus.valid_o), 32'hB);
        #3 rst_ni = 1'b0;
        #1;
        chk("mid-rst valid", 32'(bus.valid_o), 32'h0);
        for (int k = 0; k < 4; k++)
            chk("mid-rst data", out_data(k), 32'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        bus.sel_i = 2'd3;
        #1 chk("post-rst ready", 32'(bus.ready_o), 32'h1);
        push(2'd3, 32'hE0);
        chk("post-rst valid", 32'(bus.valid_o), 32'h8);
        chk("post-rst data", bus.out3_data_o, 32'hE0);
        bus.ready_i = 4'b1000;
        cyc();
        chk("post-rst empty", 32'(bus.valid_o), 32'h0);
        bus.ready_i = 4'b0000;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/demux4_stream.md
# demux4_stream

Buffered 1-to-4 stream demultiplexer: accepts one data word per cycle on a valid/ready input and steers it, by a 2-bit select, to one of four independent valid/ready output channels. Each output channel has its own 2-entry FIFO, so a stalled consumer blocks only traffic addressed to it. It is the steering counterpart of `mux4` and distributes results from a single producer to up to four consumers, for example write-back or peripheral ports.

## Interface
Parameters:
- `DataWidth`, default 32: width of every data path.

Ports:
- `clk_i`  in  1  clock. Everything is rising-edge.
- `rst_ni`  in  1  reset. Asynchronous, active-low.
- `sel_i`  in  2  destination channel for the current input word.
- `data_i`  in  DataWidth  input word.
- `valid_i`  in  1  input word present.
- `ready_o`  out  1  the block can accept the input word this cycle.
- `out0_data_o`, `out1_data_o`, `out2_data_o`, `out3_data_o`  out  DataWidth each  head word of channel k.
- `valid_o`  out  4  bit k means channel k has a word.
- `ready_i`  in  4  bit k means the consumer of channel k takes the word this cycle.

## Operation
- Per-channel state:
  - two storage entries;
  - read pointer (1 bit);
  - write pointer (1 bit);
  - occupancy `occ[k]`, range 0..2.
- Push:
  - Condition: `valid_i && ready_o`.
  - The word is written to channel `sel_i` at its write pointer.
  - That channel's write pointer toggles and its occupancy increments.
- `ready_o = (occ[sel_i] != 2)`.
  - Combinational from `sel_i` and registered occupancy only.
  - It never depends on `ready_i` or `valid_i`.
- Pop on channel k:
  - Condition: `valid_o[k] && ready_i[k]`.
  - The read pointer toggles and the occupancy decrements.
- Outputs per channel:
  - `valid_o[k] = (occ[k] != 0)`.
  - `outk_data_o` = the entry at the read pointer, driven directly from storage.
- Simultaneous push and pop on the same channel: occupancy is unchanged, both pointers advance, and FIFO order is preserved.
- A push on one channel and pops on other channels in the same cycle are fully independent.
- A full channel cannot accept a push, even if it pops in the same cycle. The producer sees `ready_o = 0` and retries in the next cycle.
- Per-channel ordering: words leave in exactly the order they were accepted.
- No cross-channel ordering is guaranteed.
- `sel_i` and `data_i` are ignored when `valid_i = 0`.
- `ready_i[k]` is ignored when `valid_o[k] = 0`.
- Occupancy never exceeds 2 and never underflows. Assertions must check both.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - all occupancies, pointers and storage entries are cleared to 0;
  - `valid_o = 4'b0000`;
  - all `outk_data_o = 0`;
  - `ready_o = 1` for any `sel_i`.
- Reset mid-operation discards all buffered words immediately, without waiting for a clock edge.
- Latency: a word accepted at edge N shows on `outk_data_o` with `valid_o[k] = 1` after edge N, i.e. in cycle N+1. There is no combinational path from input to output.
- Throughput:
  - Sustained 1 word/cycle to a single channel whose consumer holds `ready_i = 1` (steady occupancy 1).
  - Aggregate 1 word/cycle in total.
- Backpressure: after 2 accepts with no pops, `ready_o` drops in the next cycle while `sel_i` selects that channel.
- `ready_o` may change within a cycle when `sel_i` changes. The producer must hold `valid_i`, `sel_i` and `data_i` stable until a handshake completes.

## Test plan
- Reset then single push: `sel_i = 2`, `data_i = 0xA5A5_0001`, one cycle of `valid_i`.
  - Required: `valid_o = 4'b0100`, `out2_data_o = 0xA5A5_0001` in the next cycle, all other valid bits 0.
  - After a pop with `ready_i[2] = 1`: `valid_o = 0`.
- Backpressure: `ready_i = 0`, push 0x11, 0x22, 0x33 to channel 1.
  - Required: 0x11 and 0x22 are accepted, then `ready_o = 0` while `sel_i = 1`.
  - Switching `sel_i = 3` raises `ready_o = 1` with no clock edge.
  - Releasing `ready_i[1]` yields 0x11, then 0x22, then (after retry) 0x33.
- Streaming: push 0x100..0x10F to channel 0 on consecutive cycles with `ready_i[0] = 1`.
  - Required: 16 handshakes in 16 cycles.
  - Outputs appear in order, each one cycle after its accept.
  - Occupancy never exceeds 1.
- Independence: fill channel 0 (occupancy 2, stalled), then push 0xBEEF to channel 3.
  - Required: accepted the same cycle and popped next cycle.
  - Channel 0 contents unchanged.
- Push/pop same cycle at occupancy 1 on channel 2 (head 0x5, pushing 0x6).
  - Required: occupancy stays 1 and the head becomes 0x6.
- Reset mid-stream: occupancies {2,1,0,2}, assert `rst_ni = 0` between edges.
  - Required: `valid_o = 0` and all data outputs are 0 immediately.
  - After release: `ready_o = 1`, and a new push to channel 3 emerges first.
